// File: rtl/qspi_pkg.sv
// Shared constants and state encoding for the QSPI ROM responder.
// Opcode, XIP mode pattern and per-phase nibble counts.
package qspi_pkg;

   localparam logic [7:0] QSPI_CMD_FAST_READ_QIO = 8'hEB;
   localparam logic [1:0] QSPI_MODE_XIP          = 2'b10;

   localparam int ADDR_NIBBLES = 6;
   localparam int MODE_NIBBLES = 2;
   localparam int BYTE_NIBBLES = 2;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      MODE,
      DUMMY,
      DATA,
      IGNORE
   } qspi_state_t;

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchroniser for CS#, SCK and SD[3:0] kept in one bundle,
// plus SCK rise/fall pulses derived from the synchronised SCK.
module qspi_edge_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       select,
   input  logic       sck,
   input  logic [3:0] data,
   output logic       select_s,
   output logic [3:0] data_s,
   output logic       sck_rise,
   output logic       sck_fall
);

   logic [5:0] meta;
   logic [5:0] sync;
   logic       sck_q;

   // CS# resets to its idle (high) level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 6'b10_0000;
         sync  <= 6'b10_0000;
         sck_q <= 1'b0;
      end else begin
         meta  <= {select, sck, data};
         sync  <= meta;
         sck_q <= sync[4];
      end
   end

   assign select_s = sync[5];
   assign data_s   = sync[3:0];
   assign sck_rise = sync[4] & ~sck_q;
   assign sck_fall = ~sync[4] & sck_q;

endmodule

// File: rtl/qspi_rom_responder.sv
// Quad-I/O NOR flash emulator answering Fast Read Quad I/O (0xEB)
// with continuous-read support, served from a synchronous byte memory.
module qspi_rom_responder
   import qspi_pkg::*;
#(
   parameter int ADDR_BITS     = 24,
   parameter int MEM_ADDR_BITS = 16,
   parameter int DUMMY_CLKS    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     spi_select,
   input  logic                     spi_clk,
   input  logic [3:0]               spi_data_in,
   output logic [3:0]               spi_data_out,
   output logic [3:0]               spi_data_oe,
   output logic [MEM_ADDR_BITS-1:0] mem_addr,
   output logic                     mem_rd,
   input  logic [7:0]               mem_data,
   output logic                     xip_active,
   output logic                     cmd_error
);

   logic       select_s;
   logic [3:0] data_s;
   logic       sck_rise;
   logic       sck_fall;

   qspi_edge_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .select   (spi_select),
      .sck      (spi_clk),
      .data     (spi_data_in),
      .select_s (select_s),
      .data_s   (data_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall)
   );

   qspi_state_t            state, state_n;
   logic [7:0]             cnt, cnt_n;
   logic [7:0]             cmd, cmd_n;
   logic [ADDR_BITS-1:0]   addr, addr_n;
   logic [3:0]             mode_hi, mode_n;
   logic                   xip_n, err_n, rd_n, rd_q;
   logic [3:0]             oe_n, out_n;
   logic [MEM_ADDR_BITS-1:0] maddr_n;
   logic [7:0]             sh, sh_n, pre, pre_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         cmd          <= '0;
         addr         <= '0;
         mode_hi      <= '0;
         xip_active   <= 1'b0;
         cmd_error    <= 1'b0;
         spi_data_oe  <= '0;
         spi_data_out <= '0;
         mem_rd       <= 1'b0;
         mem_addr     <= '0;
         rd_q         <= 1'b0;
         sh           <= '0;
         pre          <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         cmd          <= cmd_n;
         addr         <= addr_n;
         mode_hi      <= mode_n;
         xip_active   <= xip_n;
         cmd_error    <= err_n;
         spi_data_oe  <= oe_n;
         spi_data_out <= out_n;
         mem_rd       <= rd_n;
         mem_addr     <= maddr_n;
         rd_q         <= mem_rd;
         sh           <= sh_n;
         pre          <= pre_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cmd_n   = cmd;
      addr_n  = addr;
      mode_n  = mode_hi;
      xip_n   = xip_active;
      err_n   = cmd_error;
      oe_n    = spi_data_oe;
      out_n   = spi_data_out;
      rd_n    = 1'b0;
      maddr_n = mem_addr;
      sh_n    = sh;
      pre_n   = pre;

      // memory returns data one clk after the strobe
      if (rd_q) begin
         pre_n = mem_data;
         if (state == DUMMY) sh_n = mem_data;
      end

      if (select_s) begin
         state_n = IDLE;
         cnt_n   = '0;
         oe_n    = '0;
         out_n   = '0;
      end else begin
         unique case (state)
            IDLE: state_n = xip_active ? ADDR : CMD;
            CMD: if (sck_rise) begin
               cmd_n = {cmd[6:0], data_s[0]};
               cnt_n = cnt + 8'd1;
               if (cnt == 8'd7) begin
                  cnt_n = '0;
                  if (cmd_n == QSPI_CMD_FAST_READ_QIO) begin
                     state_n = ADDR;
                  end else begin
                     err_n   = 1'b1;
                     state_n = IGNORE;
                  end
               end
            end
            ADDR: if (sck_rise) begin
               addr_n = {addr[ADDR_BITS-5:0], data_s};
               cnt_n  = cnt + 8'd1;
               if (cnt == 8'(ADDR_NIBBLES - 1)) begin
                  cnt_n   = '0;
                  state_n = MODE;
               end
            end
            MODE: if (sck_rise) begin
               cnt_n = cnt + 8'd1;
               if (cnt == 8'(MODE_NIBBLES - 1)) begin
                  xip_n   = (mode_hi[1:0] == QSPI_MODE_XIP);
                  cnt_n   = '0;
                  state_n = DUMMY;
               end else begin
                  mode_n = data_s;
               end
            end
            DUMMY: if (sck_rise) begin
               cnt_n = cnt + 8'd1;
               if (cnt == 8'd0) begin
                  maddr_n = addr[MEM_ADDR_BITS-1:0];
                  rd_n    = 1'b1;
               end
               if (cnt == 8'(DUMMY_CLKS - 1)) begin
                  cnt_n   = '0;
                  state_n = DATA;
               end
            end
            DATA: if (sck_fall) begin
               oe_n = '1;
               if (cnt == 8'(BYTE_NIBBLES - 1)) begin
                  // low nibble out, prefetch the following byte
                  out_n   = sh[3:0];
                  addr_n  = addr + ADDR_BITS'(1);
                  maddr_n = addr_n[MEM_ADDR_BITS-1:0];
                  rd_n    = 1'b1;
                  cnt_n   = '0;
               end else begin
                  sh_n  = pre;
                  out_n = pre[7:4];
                  cnt_n = cnt + 8'd1;
               end
            end
            IGNORE: state_n = IGNORE;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule
